// File: rtl/uart_hex_loader.sv
// ============================================================================
// uart_hex_loader : 8N1 UART receiver + "$AAAA#HH HH..\r" parser -> BRAM writes
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_hex_loader #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              RESET_n,
  input  logic              RXpin,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              line_done,
  output logic              err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CR     = 8'd13;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_HASH, P_DHI, P_DLO, P_SEP} p_state_t;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [7:0] v;
    v = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = c - 8'h30;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      v = c - 8'h37;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      v = c - 8'h57;
      return {1'b1, v[3:0]};
    end
    return 5'b0_0000;
  endfunction

  logic              sync1_q, sync2_q, prev_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_vld_q, rx_vld_d;
  logic              ferr_q, ferr_d;

  p_state_t          p_state_q, p_state_d;
  logic [15:0]       acc_q, acc_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        hi_q, hi_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              line_done_q, line_done_d;
  logic              err_q, err_d;

  logic              is_hex;
  logic [3:0]        digit;

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_vld_q    <= 1'b0;
      ferr_q      <= 1'b0;
      p_state_q   <= P_IDLE;
      acc_q       <= '0;
      dcnt_q      <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= RXpin;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_vld_q    <= rx_vld_d;
      ferr_q      <= ferr_d;
      p_state_q   <= p_state_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
      err_q       <= err_d;
    end
  end

  // Receiver: bit sampling is timed from the synchronized falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_vld_d   = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_vld_d   = sync2_q;
          ferr_d     = !sync2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    {is_hex, digit} = hex_dec(shift_q);
  end

  // Line parser: shift_q holds the received byte while rx_vld_q is high.
  always_comb begin
    p_state_d   = p_state_q;
    acc_d       = acc_q;
    dcnt_d      = dcnt_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_done_d = 1'b0;
    err_d       = 1'b0;
    if (ferr_q) begin
      err_d     = 1'b1;
      p_state_d = P_IDLE;
    end else if (rx_vld_q) begin
      if (shift_q == CH_DOLLAR) begin
        acc_d     = '0;
        dcnt_d    = '0;
        p_state_d = P_ADDR;
      end else begin
        case (p_state_q)
          P_IDLE: ;
          P_ADDR: begin
            if (is_hex) begin
              acc_d  = {acc_q[11:0], digit};
              dcnt_d = dcnt_q + 2'd1;
              if (dcnt_q == 2'd3) p_state_d = P_HASH;
            end else begin
              err_d     = 1'b1;
              p_state_d = P_IDLE;
            end
          end
          P_HASH: begin
            if (shift_q == CH_HASH) begin
              addr_d    = acc_q[ADDR_W-1:0];
              p_state_d = P_DHI;
            end else begin
              err_d     = 1'b1;
              p_state_d = P_IDLE;
            end
          end
          P_DHI: begin
            if (is_hex) begin
              hi_d      = digit;
              p_state_d = P_DLO;
            end else if (shift_q == CH_CR) begin
              line_done_d = 1'b1;
              p_state_d   = P_IDLE;
            end else begin
              err_d     = 1'b1;
              p_state_d = P_IDLE;
            end
          end
          P_DLO: begin
            if (is_hex) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {hi_q, digit};
              addr_d    = addr_q + ADDR_W'(1);
              p_state_d = P_SEP;
            end else begin
              err_d     = 1'b1;
              p_state_d = P_IDLE;
            end
          end
          P_SEP: begin
            if (shift_q == CH_SPACE) begin
              p_state_d = P_DHI;
            end else if (shift_q == CH_CR) begin
              line_done_d = 1'b1;
              p_state_d   = P_IDLE;
            end else begin
              err_d     = 1'b1;
              p_state_d = P_IDLE;
            end
          end
          default: p_state_d = P_IDLE;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign line_done = line_done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_hex_loader.sv
// ============================================================================
// tb_uart_hex_loader : directed line stimulus checked against a line-level model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_hex_loader;

  localparam int CLK_HZ = 24000000;
  localparam int BAUD   = 1000000;
  localparam int ADDR_W = 10;
  localparam int DIV    = CLK_HZ / BAUD;

  logic              clk = 1'b0;
  logic              RESET_n = 1'b0;
  logic              RXpin = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              line_done;
  logic              err;

  uart_hex_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .RESET_n(RESET_n), .RXpin(RXpin), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .line_done(line_done), .err(err)
  );

  always #20.833 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int kind; int addr; int data;} ev_t;  // kind 0=write 1=line_done 2=err
  ev_t        exq[$];
  int         wa_log[$];
  int         wd_log[$];
  int         n_ld = 0;
  int         n_err = 0;
  logic [7:0] lbuf[$];
  bit         active = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hexv(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  task automatic expect_ev(input int k, input int a, input int d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exq.push_back(e);
  endtask

  task automatic model_fail();
    expect_ev(2, 0, 0);
    active = 1'b0;
  endtask

  // Line model: judge each byte by its position after '$' in the buffered line.
  task automatic model_byte(input logic [7:0] c);
    int p, j, base;
    if (c == 8'h24) begin
      lbuf.delete();
      active = 1'b1;
      return;
    end
    if (!active) return;
    lbuf.push_back(c);
    p = lbuf.size() - 1;
    if (p < 4) begin
      if (hexv(c) < 0) model_fail();
    end else if (p == 4) begin
      if (c != 8'h23) model_fail();
    end else begin
      j = p - 5;
      base = 0;
      for (int k = 0; k < 4; k++) base = base * 16 + hexv(lbuf[k]);
      case (j % 3)
        0: begin
          if (c == 8'd13) begin expect_ev(1, 0, 0); active = 1'b0; end
          else if (hexv(c) < 0) model_fail();
        end
        1: begin
          if (hexv(c) < 0) model_fail();
          else expect_ev(0, (base + j / 3) % (1 << ADDR_W), hexv(lbuf[p-1]) * 16 + hexv(c));
        end
        default: begin
          if (c == 8'd13) begin expect_ev(1, 0, 0); active = 1'b0; end
          else if (c != 8'h20) model_fail();
        end
      endcase
    end
  endtask

  task automatic bit_time(input logic v);
    RXpin = v;
    repeat (DIV) @(negedge clk);
  endtask

  // Expectations are queued at stop-bit start, so any output must land inside the stop bit.
  task automatic send_byte(input logic [7:0] c, input bit stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(c[i]);
    if (stop_ok) model_byte(c);
    else model_fail();
    bit_time(stop_ok);
    if (!stop_ok) bit_time(1'b1);
    chk($sformatf("pending outputs after byte 0x%0h", c), exq.size(), 0);
    exq.delete();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  always @(negedge clk) begin
    int n, k;
    ev_t e;
    if (RESET_n) begin
      n = int'(wr_en) + int'(line_done) + int'(err);
      if (n > 1) chk("exclusive pulses", n, 1);
      if (n > 0) begin
        if (wr_en) begin wa_log.push_back(int'(wr_addr)); wd_log.push_back(int'(wr_data)); end
        if (line_done) n_ld++;
        if (err) n_err++;
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: wr_en=%0b addr=0x%0h data=0x%0h line_done=%0b err=%0b, expected none",
                   wr_en, wr_addr, wr_data, line_done, err);
        end else begin
          e = exq.pop_front();
          k = wr_en ? 0 : (line_done ? 1 : 2);
          chk("event kind", k, e.kind);
          if (k == 0) begin
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_data", int'(wr_data), e.data);
          end
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " wr_en"}, int'(wr_en), 0);
    chk({tag, " wr_addr"}, int'(wr_addr), 0);
    chk({tag, " wr_data"}, int'(wr_data), 0);
    chk({tag, " line_done"}, int'(line_done), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  initial begin
    int w0, e0, l0;
    repeat (5) @(negedge clk);
    chk_outputs_zero("reset");
    RESET_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic line
    w0 = wa_log.size(); l0 = n_ld; e0 = n_err;
    send_str("$0010#A5 3C\015");
    chk("t1 write count", wa_log.size() - w0, 2);
    chk("t1 addr0", wa_log[w0], 'h010);
    chk("t1 data0", wd_log[w0], 'hA5);
    chk("t1 addr1", wa_log[w0+1], 'h011);
    chk("t1 data1", wd_log[w0+1], 'h3C);
    chk("t1 line_done", n_ld - l0, 1);
    chk("t1 err", n_err - e0, 0);

    // address wrap and truncation
    w0 = wa_log.size();
    send_str("$03FF#11 22\015");
    send_str("$1234#56\015");
    chk("t2 write count", wa_log.size() - w0, 3);
    chk("t2 wrap addr0", wa_log[w0], 'h3FF);
    chk("t2 wrap addr1", wa_log[w0+1], 'h000);
    chk("t2 wrap data1", wd_log[w0+1], 'h22);
    chk("t2 trunc addr", wa_log[w0+2], 'h234);

    // syntax error then recovery, lowercase digits
    w0 = wa_log.size(); e0 = n_err; l0 = n_ld;
    send_str("$0000#4G");
    chk("t3 err count", n_err - e0, 1);
    chk("t3 no write", wa_log.size() - w0, 0);
    send_str("$0001#ab\015");
    chk("t3 addr", wa_log[w0], 'h001);
    chk("t3 data", wd_log[w0], 'hAB);
    chk("t3 line_done", n_ld - l0, 1);

    // frame error mid-line; following data ignored
    w0 = wa_log.size(); e0 = n_err; l0 = n_ld;
    send_str("$0006#12 ");
    send_byte(8'h33, 1'b0);
    send_str("45 67\015");
    chk("t4 write count", wa_log.size() - w0, 1);
    chk("t4 err count", n_err - e0, 1);
    chk("t4 line_done", n_ld - l0, 0);

    // glitch and '$' restart
    w0 = wa_log.size(); e0 = n_err;
    RXpin = 1'b0;
    #300;
    RXpin = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("t5 glitch err", n_err - e0, 0);
    send_str("$0002#7$0003#5A\015");
    chk("t5 write count", wa_log.size() - w0, 1);
    chk("t5 addr", wa_log[w0], 'h003);
    chk("t5 data", wd_log[w0], 'h5A);
    chk("t5 err", n_err - e0, 0);

    // reset during the last '9' (0x39) of "$0004#99"
    w0 = wa_log.size();
    send_str("$0004#9");
    bit_time(1'b0); bit_time(1'b1); bit_time(1'b0); bit_time(1'b0);
    RXpin = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    RESET_n = 1'b0;
    #1;
    chk_outputs_zero("mid-byte reset");
    exq.delete(); lbuf.delete(); active = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    RXpin = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    RESET_n = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    bit_time(1'b1); bit_time(1'b0); bit_time(1'b0); bit_time(1'b1);
    repeat (12 * DIV) @(negedge clk);
    chk("t6 no write after reset", wa_log.size() - w0, 0);
    send_str("$0005#C3\015");
    chk("t6 fresh addr", wa_log[w0], 'h005);
    chk("t6 fresh data", wd_log[w0], 'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
